// File: rtl/alu_pkg.sv
// Shared definitions for the ALU with iterative multiply/divide.
package alu_pkg;

    // Op codes on ctl
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SLTU  = 4'd3;
    localparam logic [3:0] ALU_MFHI  = 4'd4;
    localparam logic [3:0] ALU_MFLO  = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_NAND  = 4'd7;
    localparam logic [3:0] ALU_MULTU = 4'd8;
    localparam logic [3:0] ALU_DIVU  = 4'd9;
    localparam logic [3:0] ALU_NOR   = 4'd12;
    localparam logic [3:0] ALU_XOR   = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Step counter must hold the value W itself
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// The 2W accumulator holds {hi, lo}: for multiply the multiplier starts in the
// low half and is shifted out as product bits shift in; for divide the
// dividend starts in the low half, the remainder grows in the high half and
// quotient bits shift in at the bottom.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           div_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] res_o
);

    localparam int CW = cnt_width(W);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           div_q, div_d;
    logic [W-1:0]   opr_q, opr_d;
    logic [2*W-1:0] acc_q, acc_d;

    logic [W:0]     mul_sum;
    logic [2*W:0]   div_sh;
    logic [W:0]     div_trial;
    logic [2*W-1:0] step;

    // One iteration of the selected algorithm applied to the current accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opr_q} : '0);
        div_sh    = {acc_q, 1'b0};
        div_trial = div_sh[2*W:W] - {1'b0, opr_q};
        if (div_q) begin
            // No borrow means the divisor fits: keep the difference, quotient bit 1.
            // A zero divisor always fits, which yields all-ones quotient and hi=a.
            if (!div_trial[W]) step = {div_trial[W-1:0], div_sh[W-1:1], 1'b1};
            else               step = div_sh[2*W-1:0];
        end else begin
            step = {mul_sum, acc_q[W-1:1]};
        end
    end

    // Load operands on start, otherwise iterate while the counter is non-zero
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        opr_d = opr_q;
        acc_d = acc_q;
        if (start_i) begin
            cnt_d = CW'(W);
            div_d = div_i;
            opr_d = div_i ? b_i : a_i;
            acc_d = {{W{1'b0}}, (div_i ? a_i : b_i)};
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            acc_d = step;
        end
    end

    // Datapath and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            opr_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            opr_q <= opr_d;
            acc_q <= acc_d;
        end
    end

    // The step taken while the counter is 1 is the last one
    assign done_o = (cnt_q == CW'(1));
    assign res_o  = step;

endmodule

// File: rtl/alu_muldiv.sv
// Registered ALU with single-cycle ops plus iterative multu/divu and HI/LO.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   ctl,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    output logic [W-1:0] out,
    output logic         zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    state_e         state_q, state_d;
    logic [W-1:0]   out_q, out_d;
    logic           zero_q, zero_d;
    logic           vld_q, vld_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           accept;
    logic           start;
    logic [W-1:0]   alu_res;
    logic           md_done;
    logic [2*W-1:0] md_res;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign start    = accept && (ctl == ALU_MULTU || ctl == ALU_DIVU);

    muldiv_iter #(.W(W)) u_md (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .div_i   (ctl == ALU_DIVU),
        .a_i     (a),
        .b_i     (b),
        .done_o  (md_done),
        .res_o   (md_res)
    );

    // Single-cycle op mux; undefined codes produce zero
    always_comb begin
        alu_res = '0;
        case (ctl)
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_ADD:  alu_res = a + b;
            ALU_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            ALU_SUB:  alu_res = a - b;
            ALU_NAND: alu_res = ~(a & b);
            ALU_NOR:  alu_res = ~(a | b);
            ALU_XOR:  alu_res = a ^ b;
            default:  alu_res = '0;
        endcase
    end

    // FSM next state and result register updates
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        zero_d  = zero_q;
        vld_d   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ctl == ALU_MULTU) begin
                        state_d = ST_MUL;
                    end else if (ctl == ALU_DIVU) begin
                        state_d = ST_DIV;
                    end else begin
                        out_d  = alu_res;
                        zero_d = (alu_res == '0);
                        vld_d  = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    state_d = ST_IDLE;
                    hi_d    = md_res[2*W-1:W];
                    lo_d    = md_res[W-1:0];
                    out_d   = md_res[W-1:0];
                    zero_d  = (md_res[W-1:0] == '0);
                    vld_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            zero_q  <= 1'b1;
            vld_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign out_valid = vld_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at W=32 plus a W=8 instance for multu.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ctl;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic [W-1:0] out;
    logic         zero;
    logic [W-1:0] hi, lo;

    logic         in_valid8;
    logic         in_ready8;
    logic [3:0]   ctl8;
    logic [7:0]   a8, b8;
    logic         out_valid8;
    logic [7:0]   out8;
    logic         zero8;
    logic [7:0]   hi8, lo8;

    int n_tests = 0;
    int n_fail  = 0;

    alu_muldiv #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctl(ctl), .a(a), .b(b), .out_valid(out_valid), .out(out),
        .zero(zero), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .ctl(ctl8), .a(a8), .b(b8), .out_valid(out_valid8), .out(out8),
        .zero(zero8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one single-cycle op and check the pulse right after the accepting edge
    task automatic short_op(input string tag, input logic [3:0] c,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] ex);
        ctl = c; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".vld"},  out_valid, 1);
        check({tag, ".out"},  out, ex);
        check({tag, ".zero"}, zero, (ex == 0));
    endtask

    // Issue multu/divu, hold in_valid high with another op while busy
    task automatic long_op(input string tag, input logic [3:0] c,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int early;
        ctl = c; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        ctl = 4'd2; a = 32'd1; b = 32'd1;
        n = 0; early = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) early++;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({tag, ".lat"},   n, W);
        check({tag, ".busy"},  early, 0);
        check({tag, ".hi"},    hi, ehi);
        check({tag, ".lo"},    lo, elo);
        check({tag, ".out"},   out, elo);
        check({tag, ".rdy"},   in_ready, 1);
        @(posedge clk); #1;
        check({tag, ".pulse"}, out_valid, 0);
    endtask

    logic [3:0]  bc [5] = '{4'd0, 4'd12, 4'd13, 4'd7, 4'd3};
    logic [31:0] ba [5] = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'd1};
    logic [31:0] bb [5] = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd2};
    logic [31:0] be [5] = '{32'h00F0_000F, 32'h000F_F000, 32'hFF00_0FF0, 32'hFF0F_FFF0, 32'd1};

    initial begin
        int n;
        int pulses;
        rst = 1'b1; in_valid = 1'b0; ctl = '0; a = '0; b = '0;
        in_valid8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out",  out, 0);
        check("rst.zero", zero, 1);
        check("rst.vld",  out_valid, 0);
        check("rst.hi",   hi, 0);
        check("rst.lo",   lo, 0);
        check("rst.rdy",  in_ready, 1);
        rst = 1'b0;

        short_op("add", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        short_op("sub", 4'd6, 32'd5, 32'd5, 32'd0);
        short_op("undef", 4'd11, 32'h1234, 32'h5678, 32'd0);

        // Back-to-back single-cycle ops
        for (int i = 0; i < 5; i++) begin
            ctl = bc[i]; a = ba[i]; b = bb[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("b2b%0d.vld", i), out_valid, 1);
            check($sformatf("b2b%0d.out", i), out, be[i]);
        end
        in_valid = 1'b0;

        long_op("multu", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        short_op("mfhi", 4'd4, 32'd0, 32'd0, 32'hFFFF_FFFE);
        short_op("mflo", 4'd5, 32'd0, 32'd0, 32'h0000_0001);
        long_op("divu", 4'd9, 32'd100, 32'd7, 32'd2, 32'd14);
        long_op("div0", 4'd9, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

        // Reset at step 10 of a multu; an op presented with reset is dropped
        ctl = 4'd8; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; ctl = 4'd1; a = 32'd1; b = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("abort.vld",  out_valid, 0);
        check("abort.hi",   hi, 0);
        check("abort.lo",   lo, 0);
        check("abort.rdy",  in_ready, 1);
        check("abort.out",  out, 0);
        pulses = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("abort.nopulse", pulses, 0);
        short_op("post", 4'd2, 32'd2, 32'd3, 32'd5);

        // Narrow instance multu
        ctl8 = 4'd8; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8.lat", n, 8);
        check("w8.hi",  hi8, 8'hFE);
        check("w8.lo",  lo8, 8'h01);
        check("w8.out", out8, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
